// File: rtl/commit_trace_pkg.sv
// Shared types for the commit trace transmitter: record kinds, record lengths,
// the buffered record layout and helpers to turn a record into stream words.
package commit_trace_pkg;

  typedef enum logic [2:0] {
    KIND_REG   = 3'd0,
    KIND_LD    = 3'd1,
    KIND_ST    = 3'd2,
    KIND_OTHER = 3'd3,
    KIND_HALT  = 3'd4
  } kind_e;

  localparam logic [2:0] LEN_REG   = 3'd5;
  localparam logic [2:0] LEN_LD    = 3'd6;
  localparam logic [2:0] LEN_ST    = 3'd6;
  localparam logic [2:0] LEN_OTHER = 3'd4;
  localparam logic [2:0] LEN_HALT  = 3'd5;

  typedef struct packed {
    kind_e       kind;
    logic [3:0]  write_reg;
    logic [15:0] inum;
    logic [15:0] pc;
    logic [15:0] inst;
    logic [15:0] field_a;
    logic [15:0] field_b;
  } trace_entry_t;

  localparam int ENTRY_W = $bits(trace_entry_t);

  function automatic logic [2:0] rec_len(kind_e k);
    case (k)
      KIND_REG:  return LEN_REG;
      KIND_LD:   return LEN_LD;
      KIND_ST:   return LEN_ST;
      KIND_HALT: return LEN_HALT;
      default:   return LEN_OTHER;
    endcase
  endfunction

  // Word idx of a record on the wire; header word first, then fixed fields.
  function automatic logic [15:0] rec_word(trace_entry_t e, logic [2:0] idx);
    case (idx)
      3'd0:    return {e.kind, 9'b0, e.write_reg};
      3'd1:    return e.inum;
      3'd2:    return e.pc;
      3'd3:    return e.inst;
      3'd4:    return e.field_a;
      default: return e.field_b;
    endcase
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO for trace records; a push into a full FIFO is still
// accepted when a pop completes in the same cycle.
module trace_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, rd_ptr_q;
  logic         push_ok, pop_ok;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  // NOTE: storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/commit_trace_tx.sv
// Commit trace transmitter: classifies each enabled retirement into a record,
// buffers it and serialises records as 16-bit words on a valid/ready stream.
module commit_trace_tx
  import commit_trace_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [15:0]      pc,
  input  logic [15:0]      inst,
  input  logic             reg_write,
  input  logic [3:0]       write_reg,
  input  logic [15:0]      write_data,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [15:0]      mem_addr,
  input  logic [15:0]      mem_data,
  input  logic             hlt,
  output logic             tr_valid,
  output logic [15:0]      tr_data,
  output logic             tr_last,
  input  logic             tr_ready,
  output logic             overflow,
  output logic             done,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] rec_count
);

  typedef enum logic {ST_IDLE, ST_SEND} state_e;

  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
  logic [CNT_W-1:0] rec_count_q, rec_count_d;
  logic             halted_q, overflow_q, done_q;
  state_e           state_q;
  trace_entry_t     cur_q;
  logic [2:0]       idx_q, idx_next;
  logic             tr_valid_q, tr_last_q;
  logic [15:0]      tr_data_q;

  logic         capture_c, hs_c, last_hs_c, load_c;
  logic         fifo_full, fifo_empty;
  kind_e        kind_c;
  trace_entry_t entry_c, fifo_head;

  assign capture_c     = en && !halted_q;
  assign cycle_count_d = cycle_count_q + CNT_W'(1);
  assign rec_count_d   = rec_count_q + CNT_W'(1);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    kind_c = KIND_OTHER;
    if (reg_write && mem_read) kind_c = KIND_LD;
    else if (reg_write)        kind_c = KIND_REG;
    else if (hlt)              kind_c = KIND_HALT;
    else if (mem_write)        kind_c = KIND_ST;
  end

  always_comb begin
    entry_c           = '0;
    entry_c.kind      = kind_c;
    entry_c.write_reg = write_reg;
    entry_c.inum      = rec_count_q[15:0];
    entry_c.pc        = pc;
    entry_c.inst      = inst;
    case (kind_c)
      KIND_REG: entry_c.field_a = write_data;
      KIND_LD: begin
        entry_c.field_a = write_data;
        entry_c.field_b = mem_addr;
      end
      KIND_ST: begin
        entry_c.field_a = mem_addr;
        entry_c.field_b = mem_data;
      end
      KIND_HALT: entry_c.field_a = cycle_count_d[15:0];
      default: ;
    endcase
  end

  // A new record is loaded from IDLE, or straight after a final handshake.
  assign hs_c      = (state_q == ST_SEND) && tr_ready;
  assign last_hs_c = hs_c && tr_last_q;
  assign load_c    = !fifo_empty && ((state_q == ST_IDLE) || last_hs_c);
  assign idx_next  = idx_q + 3'd1;

  trace_fifo #(.DEPTH(DEPTH), .W(ENTRY_W)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (capture_c),
    .pop_i   (load_c),
    .wdata_i (entry_c),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_count_q <= '0;
      rec_count_q   <= '0;
      halted_q      <= 1'b0;
      overflow_q    <= 1'b0;
    end else if (capture_c) begin
      cycle_count_q <= cycle_count_d;
      rec_count_q   <= rec_count_d;
      if (kind_c == KIND_HALT)    halted_q   <= 1'b1;
      if (fifo_full && !load_c)   overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cur_q      <= '0;
      idx_q      <= '0;
      tr_valid_q <= 1'b0;
      tr_last_q  <= 1'b0;
      tr_data_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      if (last_hs_c && cur_q.kind == KIND_HALT) done_q <= 1'b1;
      if (load_c) begin
        state_q    <= ST_SEND;
        cur_q      <= fifo_head;
        idx_q      <= '0;
        tr_valid_q <= 1'b1;
        tr_last_q  <= 1'b0;
        tr_data_q  <= rec_word(fifo_head, 3'd0);
      end else if (last_hs_c) begin
        state_q    <= ST_IDLE;
        tr_valid_q <= 1'b0;
        tr_last_q  <= 1'b0;
      end else if (hs_c) begin
        idx_q     <= idx_next;
        tr_data_q <= rec_word(cur_q, idx_next);
        tr_last_q <= (idx_next == rec_len(cur_q.kind) - 3'd1);
      end
    end
  end

  assign tr_valid    = tr_valid_q;
  assign tr_data     = tr_data_q;
  assign tr_last     = tr_last_q;
  assign overflow    = overflow_q;
  assign done        = done_q;
  assign cycle_count = cycle_count_q;
  assign rec_count   = rec_count_q;

endmodule

// File: tb/tb_commit_trace_tx.sv
// Self-checking bench for commit_trace_tx: a record-level queue model checked
// every cycle, plus literal expectations for the directed scenarios.
module tb_commit_trace_tx;

  localparam int DEPTH = 8;
  localparam int CNT_W = 32;

  logic             clk, rst_n, en;
  logic [15:0]      pc, inst, write_data, mem_addr, mem_data;
  logic             reg_write, mem_read, mem_write, hlt;
  logic [3:0]       write_reg;
  logic             tr_valid, tr_last, tr_ready, overflow, done;
  logic [15:0]      tr_data;
  logic [CNT_W-1:0] cycle_count, rec_count;

  commit_trace_tx #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .pc(pc), .inst(inst),
    .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_data(mem_data), .hlt(hlt), .tr_valid(tr_valid), .tr_data(tr_data),
    .tr_last(tr_last), .tr_ready(tr_ready), .overflow(overflow), .done(done),
    .cycle_count(cycle_count), .rec_count(rec_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference model: a record is a list of words; the buffer is a queue.
  typedef struct packed {
    logic [5:0][15:0] w;
    logic [2:0]       len;
    logic             halt;
  } rec_t;

  typedef struct packed {
    logic [15:0] data;
    logic        last;
    logic        done;
    logic [31:0] cyc;
  } obs_t;

  rec_t        m_fifo[$];
  rec_t        m_cur;
  bit          m_sending, m_halted, m_ovf, m_done, m_live;
  int          m_idx;
  logic [31:0] m_cyc, m_rec;
  obs_t        obs[$];
  logic [31:0] tb_cyc = 0;

  function automatic rec_t make_rec();
    rec_t       r;
    logic [2:0] k;
    r = '0;
    if (reg_write && mem_read) begin
      k = 3'd1; r.len = 3'd6; r.w[4] = write_data; r.w[5] = mem_addr;
    end else if (reg_write) begin
      k = 3'd0; r.len = 3'd5; r.w[4] = write_data;
    end else if (hlt) begin
      k = 3'd4; r.len = 3'd5; r.w[4] = m_cyc[15:0]; r.halt = 1'b1;
    end else if (mem_write) begin
      k = 3'd2; r.len = 3'd6; r.w[4] = mem_addr; r.w[5] = mem_data;
    end else begin
      k = 3'd3; r.len = 3'd4;
    end
    r.w[0] = {k, 9'b0, write_reg};
    r.w[1] = m_rec[15:0];
    r.w[2] = pc;
    r.w[3] = inst;
    return r;
  endfunction

  task automatic model_step();
    bit   hs, lasth, pop, cap, acc;
    rec_t r;
    if (!rst_n) begin
      m_fifo.delete();
      m_sending = 0; m_halted = 0; m_ovf = 0; m_done = 0;
      m_idx = 0; m_cyc = 0; m_rec = 0; m_live = 1;
      return;
    end
    hs    = m_sending && tr_ready;
    lasth = hs && (m_idx == int'(m_cur.len) - 1);
    pop   = (m_fifo.size() != 0) && (!m_sending || lasth);
    cap   = en && !m_halted;
    acc   = 0;
    r     = '0;
    if (cap) begin
      m_cyc = m_cyc + 1;
      r     = make_rec();
      acc   = (m_fifo.size() < DEPTH) || pop;
      m_rec = m_rec + 1;
      if (r.halt) m_halted = 1;
      if (!acc) m_ovf = 1;
    end
    if (lasth) begin
      if (m_cur.halt) m_done = 1;
      m_sending = 0;
    end else if (hs) begin
      m_idx++;
    end
    if (pop) begin
      m_cur = m_fifo.pop_front();
      m_idx = 0;
      m_sending = 1;
    end
    if (cap && acc) m_fifo.push_back(r);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Compare process: outputs are sampled on the falling edge.
  initial forever begin
    @(negedge clk);
    tb_cyc = tb_cyc + 1;
    if (m_live) begin
      check("tr_valid", tr_valid, m_sending);
      if (m_sending) begin
        check("tr_data", tr_data, m_cur.w[m_idx]);
        check("tr_last", tr_last, m_idx == int'(m_cur.len) - 1);
      end
      check("overflow", overflow, m_ovf);
      check("done", done, m_done);
      check("cycle_count", cycle_count, m_cyc);
      check("rec_count", rec_count, m_rec);
      if (tr_valid && tr_ready) obs.push_back('{tr_data, tr_last, done, tb_cyc});
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  task automatic idle_inputs();
    en = 0; pc = 0; inst = 0; reg_write = 0; write_reg = 0; write_data = 0;
    mem_read = 0; mem_write = 0; mem_addr = 0; mem_data = 0; hlt = 0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle_inputs();
    wait_cycles(2);
    rst_n = 1;
    obs.delete();
  endtask

  task automatic commit(input logic [15:0] p, input logic [15:0] i, input logic rw,
                        input logic [3:0] wr, input logic [15:0] wd, input logic mr,
                        input logic mw, input logic [15:0] ma, input logic [15:0] md,
                        input logic h);
    en = 1; pc = p; inst = i; reg_write = rw; write_reg = wr; write_data = wd;
    mem_read = mr; mem_write = mw; mem_addr = ma; mem_data = md; hlt = h;
    wait_cycles(1);
  endtask

  task automatic check_words(input string name, input int base, input logic [15:0] exp[]);
    for (int k = 0; k < exp.size(); k++) begin
      if (base + k < obs.size()) check(name, obs[base + k].data, exp[k]);
      else check(name, 32'hFFFF_FFFF, exp[k]);
    end
  endtask

  initial begin
    rst_n = 0; tr_ready = 1;
    idle_inputs();
    #1;
    do_reset();
    check("reset_valid", tr_valid, 0);
    check("reset_cycles", cycle_count, 0);

    // Single REG record.
    commit(16'h0002, 16'hB3AB, 1, 4'd3, 16'h00AB, 0, 0, 0, 0, 0);
    idle_inputs();
    wait_cycles(20);
    check("t1_len", obs.size(), 5);
    check_words("t1_word", 0, '{16'h0003, 16'h0000, 16'h0002, 16'hB3AB, 16'h00AB});
    if (obs.size() == 5) begin
      check("t1_last4", obs[4].last, 1);
      check("t1_last3", obs[3].last, 0);
    end

    // Back-to-back LD then ST with no bubble.
    do_reset();
    commit(16'h0004, 16'h1111, 1, 4'd5, 16'h1234, 1, 0, 16'h0010, 0, 0);
    commit(16'h0006, 16'h2222, 0, 4'd0, 0, 0, 1, 16'h0020, 16'h5678, 0);
    idle_inputs();
    wait_cycles(25);
    check("t2_len", obs.size(), 12);
    check_words("t2_ld", 0, '{16'h2005, 16'h0000, 16'h0004, 16'h1111, 16'h1234, 16'h0010});
    check_words("t2_st", 6, '{16'h4000, 16'h0001, 16'h0006, 16'h2222, 16'h0020, 16'h5678});
    if (obs.size() == 12) begin
      check("t2_no_bubble", obs[6].cyc - obs[5].cyc, 1);
      check("t2_ld_last", obs[5].last, 1);
      check("t2_st_last", obs[11].last, 1);
    end

    // Stalled sink: 20 OTHER commits. Record 0 leaves the FIFO into the
    // serialiser, so 8 buffered + 1 in flight survive: inums 0..8.
    do_reset();
    tr_ready = 0;
    for (int i = 0; i < 20; i++) commit(16'(i), 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0);
    idle_inputs();
    check("t3_overflow", overflow, 1);
    check("t3_rec_count", rec_count, 20);
    check("t3_cycle_count", cycle_count, 20);
    tr_ready = 1;
    wait_cycles(60);
    check("t3_len", obs.size(), 36);
    for (int i = 0; i < 9; i++)
      if (4 * i + 1 < obs.size()) check("t3_inum", obs[4 * i + 1].data, i);

    // Reset during the third word of a record, with overflow still set.
    obs.delete();
    commit(16'h0050, 16'h5555, 1, 4'd2, 16'h0099, 0, 0, 0, 0, 0);
    idle_inputs();
    wait_cycles(3);
    tr_ready = 0;
    rst_n = 0;
    wait_cycles(1);
    check("t6_valid", tr_valid, 0);
    check("t6_cycles", cycle_count, 0);
    check("t6_recs", rec_count, 0);
    check("t6_overflow", overflow, 0);
    check("t6_done", done, 0);
    check("t6_sent_before", obs.size(), 2);
    rst_n = 1;
    tr_ready = 1;
    obs.delete();
    commit(16'h0040, 16'h4444, 1, 4'd1, 16'h0055, 0, 0, 0, 0, 0);
    idle_inputs();
    wait_cycles(20);
    check("t6_len", obs.size(), 5);
    check_words("t6_clean", 0, '{16'h0001, 16'h0000, 16'h0040, 16'h4444, 16'h0055});

    // Sink toggling ready mid-record.
    do_reset();
    commit(16'h0030, 16'h3333, 1, 4'd7, 16'hBEEF, 0, 0, 0, 0, 0);
    idle_inputs();
    for (int i = 0; i < 14; i++) begin
      tr_ready = (i % 2 == 0);
      wait_cycles(1);
    end
    tr_ready = 1;
    wait_cycles(20);
    check("t4_len", obs.size(), 5);
    check_words("t4_word", 0, '{16'h0007, 16'h0000, 16'h0030, 16'h3333, 16'hBEEF});

    // Halt on the sixth enabled cycle; later commits are ignored.
    do_reset();
    for (int i = 0; i < 5; i++) commit(16'(i), 16'h00F0 + 16'(i), 0, 0, 0, 0, 0, 0, 0, 0);
    commit(16'h000A, 16'hF000, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) commit(16'h0100, 16'h0100, 1, 4'd9, 16'h0077, 0, 0, 0, 0, 0);
    idle_inputs();
    wait_cycles(60);
    check("t5_len", obs.size(), 25);
    check_words("t5_halt", 20, '{16'h8000, 16'h0005, 16'h000A, 16'hF000, 16'h0006});
    if (obs.size() == 25) begin
      check("t5_last", obs[24].last, 1);
      check("t5_done_at_last", obs[24].done, 0);
    end
    check("t5_done", done, 1);
    check("t5_rec_count", rec_count, 6);
    check("t5_cycle_count", cycle_count, 6);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
